imm_encoder: RTL and testbench

- Inverse of the team's immediate sign-extender: packs a 64-bit signed immediate plus register/funct fields into a 32-bit RV64 instruction word.
- Uses the same opcode→format classification as the extender (I, S, SB, U, UJ), plus R-type pass-through.
- Two-stage valid/ready pipeline with range checking and an output transaction counter.
- Feeds the instruction-memory loader and the self-check bench, which round-trips instructions through the extender.

---
 rtl/imm_encoder.sv | 138 +++++++++++++
 tb/tb_imm_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage RV64 immediate/field packer (range checks under IMM_ENC_RANGE_CHECK_EN)
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       OP_CODE,
  input  logic [4:0]       RD,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic [2:0]       FUNCT3,
  input  logic [6:0]       FUNCT7,
  input  logic [63:0]      IMM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      INSTR,
  output logic             ERR,
  output logic [CNT_W-1:0] COUNT
);

  typedef enum logic [2:0] {
    FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_R
  } fmt_t;

  fmt_t        fmt_in;
  logic        op_bad;
  logic        rng_bad;

  logic        v1;
  fmt_t        fmt1;
  logic        err1;
  logic [6:0]  op1;
  logic [4:0]  rd1;
  logic [4:0]  rs1_1;
  logic [4:0]  rs2_1;
  logic [2:0]  f3_1;
  logic [6:0]  f7_1;
  logic [31:0] imm1;
  logic [31:0] packed_instr;

  logic        adv1;
  logic        adv2;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  always_comb begin
    fmt_in = FMT_R;
    op_bad = 1'b0;
    case (OP_CODE)
      7'b0010011, 7'b0000011, 7'b1110011: fmt_in = FMT_I;
      7'b0100011:                         fmt_in = FMT_S;
      7'b1100011, 7'b1100111:             fmt_in = FMT_SB;
      7'b0110111:                         fmt_in = FMT_U;
      7'b1101111:                         fmt_in = FMT_UJ;
      7'b0110011, 7'b0111011:             fmt_in = FMT_R;
      default:                            op_bad = 1'b1;
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  // The upper bits must be a pure sign extension of the field's top bit.
  always_comb begin
    rng_bad = 1'b0;
    case (fmt_in)
      FMT_I, FMT_S: rng_bad = !((&IMM[63:11]) || !(|IMM[63:11]));
      FMT_SB:       rng_bad = !((&IMM[63:12]) || !(|IMM[63:12])) || IMM[0];
      FMT_UJ:       rng_bad = !((&IMM[63:20]) || !(|IMM[63:20])) || IMM[0];
      FMT_U:        rng_bad = !((&IMM[63:31]) || !(|IMM[63:31])) || (|IMM[11:0]);
      default:      rng_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^IMM[63:32];
  assign rng_bad       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      fmt1  <= fmt_in;
      err1  <= op_bad || rng_bad;
      op1   <= OP_CODE;
      rd1   <= RD;
      rs1_1 <= RS1;
      rs2_1 <= RS2;
      f3_1  <= FUNCT3;
      f7_1  <= FUNCT7;
      imm1  <= IMM[31:0];
    end
  end

  // Out-of-range immediates are still packed from their low bits.
  always_comb begin
    packed_instr = {f7_1, rs2_1, rs1_1, f3_1, rd1, op1};
    case (fmt1)
      FMT_I:  packed_instr = {imm1[11:0], rs1_1, f3_1, rd1, op1};
      FMT_S:  packed_instr = {imm1[11:5], rs2_1, rs1_1, f3_1, imm1[4:0], op1};
      FMT_SB: packed_instr = {imm1[12], imm1[10:5], rs2_1, rs1_1, f3_1,
                              imm1[4:1], imm1[11], op1};
      FMT_U:  packed_instr = {imm1[31:12], rd1, op1};
      FMT_UJ: packed_instr = {imm1[20], imm1[10:1], imm1[11], imm1[19:12], rd1, op1};
      default: packed_instr = {f7_1, rs2_1, rs1_1, f3_1, rd1, op1};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      INSTR     <= 32'd0;
      ERR       <= 1'b0;
      COUNT     <= '0;
    end else begin
      if (out_valid && out_ready) begin
        COUNT <= COUNT + CNT_W'(1);
      end
      if (adv2) begin
        out_valid <= v1;
        if (v1) begin
          INSTR <= packed_instr;
          ERR   <= err1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder (scoreboard model plus directed vectors)
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  OP_CODE;
  logic [4:0]  RD;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic [2:0]  FUNCT3;
  logic [6:0]  FUNCT7;
  logic [63:0] IMM;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] INSTR;
  logic        ERR;
  logic [15:0] COUNT;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .OP_CODE(OP_CODE), .RD(RD), .RS1(RS1), .RS2(RS2), .FUNCT3(FUNCT3),
    .FUNCT7(FUNCT7), .IMM(IMM), .out_valid(out_valid), .out_ready(out_ready),
    .INSTR(INSTR), .ERR(ERR), .COUNT(COUNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } req_t;

  int passed = 0;
  int total  = 0;

  exp_t        sbq[$];
  logic [15:0] mcnt;
  bit          held;
  logic [31:0] held_instr;
  logic        held_err;

`ifdef IMM_ENC_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Range is judged on the signed value; packing follows the RISC-V field layout.
  function automatic exp_t model_enc(input req_t r);
    exp_t        e;
    longint      s;
    logic [31:0] u;
    bit          ok;
    s  = r.imm;
    u  = r.imm[31:0];
    ok = 1'b1;
    e.err = 1'b0;
    case (r.op)
      7'h13, 7'h03, 7'h73: begin
        e.instr = {u[11:0], r.rs1, r.f3, r.rd, r.op};
        ok = (s >= -2048) && (s <= 2047);
      end
      7'h23: begin
        e.instr = {u[11:5], r.rs2, r.rs1, r.f3, u[4:0], r.op};
        ok = (s >= -2048) && (s <= 2047);
      end
      7'h63, 7'h67: begin
        e.instr = {u[12], u[10:5], r.rs2, r.rs1, r.f3, u[4:1], u[11], r.op};
        ok = (s >= -4096) && (s <= 4095) && (r.imm[0] == 1'b0);
      end
      7'h37: begin
        e.instr = {u[31:12], r.rd, r.op};
        ok = (s >= -64'sd2147483648) && (s <= 64'sd2147483647) && (r.imm[11:0] == 12'd0);
      end
      7'h6F: begin
        e.instr = {u[20], u[10:1], u[11], u[19:12], r.rd, r.op};
        ok = (s >= -1048576) && (s <= 1048575) && (r.imm[0] == 1'b0);
      end
      7'h33, 7'h3B: e.instr = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      default: begin
        e.instr = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
        e.err   = 1'b1;
      end
    endcase
    if (RANGE_ON && !ok) e.err = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    req_t r;
    if (reset) begin
      sbq.delete();
      mcnt = '0;
      held = 1'b0;
    end else begin
      check("count", COUNT, mcnt);
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_instr", INSTR, held_instr);
        check("hold_err", ERR, held_err);
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("instr", INSTR, sbq[0].instr);
          check("err", ERR, sbq[0].err);
          if (out_ready) begin
            void'(sbq.pop_front());
            mcnt = mcnt + 16'd1;
          end
        end
      end
      held       = out_valid && !out_ready;
      held_instr = INSTR;
      held_err   = ERR;
      if (in_valid && in_ready) begin
        r = '{OP_CODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM};
        sbq.push_back(model_enc(r));
      end
    end
  end

  task automatic drive(input req_t r);
    OP_CODE = r.op; RD = r.rd; RS1 = r.rs1; RS2 = r.rs2;
    FUNCT3 = r.f3; FUNCT7 = r.f7; IMM = r.imm;
  endtask

  task automatic stream_step(input req_t r, input logic ordy, output bit acc);
    @(posedge clk); #1;
    drive(r);
    in_valid  = 1'b1;
    out_ready = ordy;
    @(negedge clk);
    acc = in_ready;
  endtask

  task automatic dir(input string name, input req_t r, input logic [31:0] ei, input logic ee);
    int k;
    bit acc;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 10) begin
      stream_step(r, 1'b1, acc);
      k++;
    end
    check({name, "_accept"}, acc, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 6);
    check({name, "_latency"}, k, 2);
    check({name, "_instr"}, INSTR, ei);
    check({name, "_err"}, ERR, ee);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
  endtask

  req_t reqs[5];
  req_t rq;

  initial begin
    int idx;
    int guard;
    bit a;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    OP_CODE = '0; RD = '0; RS1 = '0; RS2 = '0; FUNCT3 = '0; FUNCT7 = '0; IMM = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_instr", INSTR, 32'd0);
    check("rst_err", ERR, 1'b0);
    check("rst_count", COUNT, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);

    rq = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    dir("addi", rq, 32'hFFF00093, 1'b0);
    rq = '{7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 64'd8};
    dir("sw", rq, 32'h00512423, 1'b0);
    rq = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd4};
    dir("beq", rq, 32'hFE000EE3, 1'b0);
    rq = '{7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000};
    dir("lui", rq, 32'h123450B7, 1'b0);
    rq = '{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048};
    dir("jal", rq, 32'h001000EF, 1'b0);
    rq = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'hDEAD};
    dir("sub", rq, 32'h402081B3, 1'b0);
    rq = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048};
    dir("addi_big", rq, 32'h80000093, RANGE_ON);
    rq = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3};
    dir("beq_odd", rq, 32'h00000163, RANGE_ON);
    rq = '{7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345001};
    dir("lui_low", rq, 32'h123450B7, RANGE_ON);
    rq = '{7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0};
    dir("bad_op", rq, 32'h000000FF, 1'b1);

    pulse_reset();
    reqs[0] = '{7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5};
    reqs[1] = '{7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -64'sd16};
    reqs[2] = '{7'b1100011, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 64'd100};
    reqs[3] = '{7'b0110011, 5'd8, 5'd9, 5'd10, 3'd7, 7'd0, 64'd0};
    reqs[4] = '{7'b1101111, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2048};
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      stream_step(reqs[idx], 1'b0, a);
      if (a) idx++;
    end
    check("bp_accepts", idx, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    guard = 0;
    while (idx < 5 && guard < 20) begin
      stream_step(reqs[idx], 1'b1, a);
      if (a) idx++;
      guard++;
    end
    check("bp_all_accepted", idx, 5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while ((sbq.size() != 0 || out_valid) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("bp_drain", sbq.size(), 0);
    check("bp_count", COUNT, 16'd5);

    idx = 0;
    for (int i = 0; i < 2; i++) begin
      stream_step(reqs[i], 1'b0, a);
      if (a) idx++;
    end
    check("mid_accepts", idx, 2);
    pulse_reset();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_count", COUNT, 16'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_flushed", out_valid, 1'b0);
    check("mid_count_after", COUNT, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
